// File: rtl/doa_peak_search_if.sv
// Power-stage <-> DOA peak search bus: steering index out, power beats in, sweep result out.
// Optional spectrum outputs are present when DOA_SPECTRUM_OUT_EN is defined.
interface doa_peak_search_if #(
   parameter int unsigned WORD_LENGTH_OUT = 71,
   parameter int unsigned ANG_W           = 8,
   parameter int unsigned SNAP_W          = 4,
   parameter int unsigned ACC_W           = WORD_LENGTH_OUT + SNAP_W
);
   logic                       start;
   logic [ANG_W-1:0]           ang_idx;
   logic [WORD_LENGTH_OUT-1:0] pwr_in;
   logic                       pwr_valid;
   logic                       pwr_ready;
   logic                       busy;
   logic                       done;
   logic [ANG_W-1:0]           peak_idx;
   logic [ACC_W-1:0]           peak_pwr;
`ifdef DOA_SPECTRUM_OUT_EN
   logic                       spec_valid;
   logic [ANG_W-1:0]           spec_idx;
   logic [ACC_W-1:0]           spec_pwr;
`endif

   // master: the peak-search block; slave: sequencer / power stage side
   modport master (
      input  start, pwr_in, pwr_valid,
      output ang_idx, pwr_ready, busy, done, peak_idx, peak_pwr
`ifdef DOA_SPECTRUM_OUT_EN
      , output spec_valid, spec_idx, spec_pwr
`endif
   );

   modport slave (
      output start, pwr_in, pwr_valid,
      input  ang_idx, pwr_ready, busy, done, peak_idx, peak_pwr
`ifdef DOA_SPECTRUM_OUT_EN
      , input spec_valid, spec_idx, spec_pwr
`endif
   );
endinterface

// File: rtl/doa_peak_search.sv
// Direction-of-arrival peak search: integrates NUM_SNAP power beats per steering angle and
// reports the angle with the largest sum. DOA_SPECTRUM_OUT_EN adds per-angle spectrum outputs.
module doa_peak_search #(
   parameter int unsigned WORD_LENGTH_OUT = 71,
   parameter int unsigned NUM_ANGLES      = 181,
   parameter int unsigned ANG_W           = 8,
   parameter int unsigned NUM_SNAP        = 16,
   parameter int unsigned SNAP_W          = 4
) (
   input logic              clk,
   input logic              rst,
   doa_peak_search_if.master bus
);
   localparam int unsigned       ACC_W     = WORD_LENGTH_OUT + SNAP_W;
   localparam logic [ANG_W-1:0]  LAST_ANG  = ANG_W'(NUM_ANGLES - 1);
   localparam logic [SNAP_W-1:0] LAST_SNAP = SNAP_W'(NUM_SNAP - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_COMPARE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [ANG_W-1:0]    ang_idx, ang_nxt;
   logic [ACC_W-1:0]    acc, acc_nxt;
   logic [SNAP_W-1:0]   snap_cnt, snap_nxt;
   logic [ACC_W-1:0]    best, best_nxt;
   logic [ANG_W-1:0]    best_idx, best_idx_nxt;
   logic [ANG_W-1:0]    peak_idx, peak_idx_nxt;
   logic [ACC_W-1:0]    peak_pwr, peak_pwr_nxt;
   logic                ready_q, busy_q, done_q;
   logic                beat;
   logic                take_best;

   // Next-state and datapath decode
   always_comb begin
      state_nxt    = state;
      ang_nxt      = ang_idx;
      acc_nxt      = acc;
      snap_nxt     = snap_cnt;
      best_nxt     = best;
      best_idx_nxt = best_idx;
      peak_idx_nxt = peak_idx;
      peak_pwr_nxt = peak_pwr;
      beat         = bus.pwr_valid & ready_q;
      take_best    = (ang_idx == '0) || (acc > best);

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt = S_ACCUM;
               ang_nxt   = '0;
               acc_nxt   = '0;
               snap_nxt  = '0;
            end
         end
         S_ACCUM: begin
            if (beat) begin
               acc_nxt  = acc + ACC_W'(bus.pwr_in);
               snap_nxt = SNAP_W'(snap_cnt + 1'b1);
               if (snap_cnt == LAST_SNAP) state_nxt = S_COMPARE;
            end
         end
         S_COMPARE: begin
            // strict compare keeps the lower index on ties
            if (take_best) begin
               best_nxt     = acc;
               best_idx_nxt = ang_idx;
            end
            if (ang_idx == LAST_ANG) begin
               state_nxt    = S_DONE;
               peak_idx_nxt = best_idx_nxt;
               peak_pwr_nxt = best_nxt;
            end else begin
               state_nxt = S_ACCUM;
               ang_nxt   = ANG_W'(ang_idx + 1'b1);
               acc_nxt   = '0;
               snap_nxt  = '0;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; status flags are decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         ang_idx  <= '0;
         acc      <= '0;
         snap_cnt <= '0;
         best     <= '0;
         best_idx <= '0;
         peak_idx <= '0;
         peak_pwr <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ang_idx  <= ang_nxt;
         acc      <= acc_nxt;
         snap_cnt <= snap_nxt;
         best     <= best_nxt;
         best_idx <= best_idx_nxt;
         peak_idx <= peak_idx_nxt;
         peak_pwr <= peak_pwr_nxt;
         ready_q  <= (state_nxt == S_ACCUM);
         busy_q   <= (state_nxt != S_IDLE);
         done_q   <= (state_nxt == S_DONE);
      end
   end

   assign bus.ang_idx   = ang_idx;
   assign bus.pwr_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.peak_idx  = peak_idx;
   assign bus.peak_pwr  = peak_pwr;

`ifdef DOA_SPECTRUM_OUT_EN
   logic             spec_valid_q;
   logic [ANG_W-1:0] spec_idx_q;
   logic [ACC_W-1:0] spec_pwr_q;

   // Spectrum sample is captured on entry to COMPARE, when acc holds the final sum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_valid_q <= 1'b0;
         spec_idx_q   <= '0;
         spec_pwr_q   <= '0;
      end else begin
         spec_valid_q <= (state_nxt == S_COMPARE);
         if (state_nxt == S_COMPARE) begin
            spec_idx_q <= ang_nxt;
            spec_pwr_q <= acc_nxt;
         end
      end
   end

   assign bus.spec_valid = spec_valid_q;
   assign bus.spec_idx   = spec_idx_q;
   assign bus.spec_pwr   = spec_pwr_q;
`endif

endmodule

// File: tb/tb_doa_peak_search.sv
// Directed bench for doa_peak_search: small 4-angle/2-snapshot instance for the scenario
// checks, default-parameter instance for the full-scale no-wrap sweep.
module tb_doa_peak_search;
   logic clk;
   logic rst;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   doa_peak_search_if #(.WORD_LENGTH_OUT(16), .ANG_W(2), .SNAP_W(1)) sif ();
   doa_peak_search_if bif ();

   doa_peak_search #(
      .WORD_LENGTH_OUT(16), .NUM_ANGLES(4), .ANG_W(2), .NUM_SNAP(2), .SNAP_W(1)
   ) u_small (.clk(clk), .rst(rst), .bus(sif.master));

   doa_peak_search u_big (.clk(clk), .rst(rst), .bus(bif.master));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Run one sweep on the small instance; stall toggles pwr_valid, poke fires start while busy
   task automatic sweep_small(input string tag, input int unsigned p[4][2], input bit stall,
                              input bit poke, input int exp_cyc, input int exp_idx,
                              input int exp_pwr);
      int b, cyc, prev, changes, seq_bad, dcount;
      bit v, rdy;
      sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      cyc = 1; b = 0; v = 1'b1; prev = 0; changes = 0; seq_bad = 0; dcount = 0;
      while (cyc < 100 && dcount == 0) begin
         sif.pwr_valid = v;
         sif.pwr_in    = v ? 16'(p[sif.ang_idx][b]) : 16'hBEEF;
         sif.start     = poke && (cyc % 3 == 0);
         rdy = sif.pwr_ready;
         @(posedge clk); #1;
         cyc++;
         if (v && rdy) b = (b == 1) ? 0 : 1;
         if (stall) v = ~v;
         if (int'(sif.ang_idx) != prev) begin
            changes++;
            if (int'(sif.ang_idx) != prev + 1) seq_bad++;
            prev = int'(sif.ang_idx);
         end
         if (sif.done) dcount++;
      end
      check({tag, "_done_seen"}, 128'(dcount), 128'd1);
      check({tag, "_done_cycle"}, 128'(cyc), 128'(exp_cyc));
      check({tag, "_peak_idx"}, 128'(sif.peak_idx), 128'(exp_idx));
      check({tag, "_peak_pwr"}, 128'(sif.peak_pwr), 128'(exp_pwr));
      check({tag, "_ang_hold"}, 128'(sif.ang_idx), 128'd3);
      // a start sampled in the DONE cycle must be ignored
      sif.start     = poke;
      sif.pwr_valid = 1'b0;
      @(posedge clk); #1;
      sif.start = 1'b0;
      check({tag, "_done_width"}, 128'(sif.done), 128'd0);
      check({tag, "_idle_busy"}, 128'(sif.busy), 128'd0);
      if (poke) begin
         check({tag, "_ang_steps"}, 128'(changes), 128'd3);
         check({tag, "_ang_order"}, 128'(seq_bad), 128'd0);
         dcount = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sif.done || sif.busy) dcount++;
         end
         check({tag, "_no_restart"}, 128'(dcount), 128'd0);
      end
   endtask

   int unsigned pa[4][2];
   int unsigned pe[4][2];
   logic [127:0] big_exp;
   int cyc, dseen, n_spec, spec_bad, waitc;

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      sif.start = 1'b0; sif.pwr_valid = 1'b0; sif.pwr_in = '0;
      bif.start = 1'b0; bif.pwr_valid = 1'b0; bif.pwr_in = '0;
      pa = '{'{10, 10}, '{30, 30}, '{20, 20}, '{5, 5}};
      pe = '{'{7, 7}, '{7, 7}, '{7, 7}, '{7, 7}};

      @(posedge clk); @(posedge clk); #1;
      check("rst_ang_idx", 128'(sif.ang_idx), 128'd0);
      check("rst_busy", 128'(sif.busy), 128'd0);
      check("rst_ready", 128'(sif.pwr_ready), 128'd0);
      check("rst_done", 128'(sif.done), 128'd0);
      check("rst_peak_pwr", 128'(bif.peak_pwr), 128'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      sweep_small("basic", pa, 1'b0, 1'b0, 13, 1, 60);
      sweep_small("tie", pe, 1'b0, 1'b0, 13, 0, 14);
      sweep_small("stall", pa, 1'b1, 1'b0, 17, 1, 60);

      // abort mid-sweep: run until angle 2 is accumulating, then assert reset
      sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      sif.pwr_valid = 1'b1; sif.pwr_in = 16'd50;
      waitc = 0;
      while (!(sif.ang_idx == 2'd2 && sif.pwr_ready) && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("abort_reached_ang2", 128'(sif.ang_idx), 128'd2);
      check("abort_peak_hold", 128'(sif.peak_pwr), 128'd60);
      #2 rst = 1'b1;
      #1;
      check("abort_ang_idx", 128'(sif.ang_idx), 128'd0);
      check("abort_busy", 128'(sif.busy), 128'd0);
      check("abort_ready", 128'(sif.pwr_ready), 128'd0);
      check("abort_peak_idx", 128'(sif.peak_idx), 128'd0);
      check("abort_peak_pwr", 128'(sif.peak_pwr), 128'd0);
      dseen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (sif.done) dseen++;
      end
      @(negedge clk); rst = 1'b0;
      sif.pwr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (sif.done || sif.busy) dseen++;
      end
      check("abort_no_done", 128'(dseen), 128'd0);
      sweep_small("fresh", pa, 1'b0, 1'b0, 13, 1, 60);
      sweep_small("poke", pa, 1'b0, 1'b1, 13, 1, 60);

      // full-size sweep with maximum power words on every beat
      big_exp = {57'd0, {71{1'b1}}} << 4;
      bif.pwr_in = '1;
      bif.pwr_valid = 1'b1;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      cyc = 1; dseen = 0; n_spec = 0; spec_bad = 0;
      while (cyc < 5000 && dseen == 0) begin
         @(posedge clk); #1;
         cyc++;
`ifdef DOA_SPECTRUM_OUT_EN
         if (bif.spec_valid) begin
            if (int'(bif.spec_idx) != n_spec || 128'(bif.spec_pwr) != big_exp) spec_bad++;
            n_spec++;
         end
`endif
         if (bif.done) dseen++;
      end
      check("big_done_seen", 128'(dseen), 128'd1);
      check("big_done_cycle", 128'(cyc), 128'd3078);
      check("big_peak_idx", 128'(bif.peak_idx), 128'd0);
      check("big_peak_pwr", 128'(bif.peak_pwr), big_exp);
      check("big_ang_hold", 128'(bif.ang_idx), 128'd180);
`ifdef DOA_SPECTRUM_OUT_EN
      check("big_spec_count", 128'(n_spec), 128'd181);
      check("big_spec_order", 128'(spec_bad), 128'd0);
`endif
      bif.pwr_valid = 1'b0;
      @(posedge clk); #1;
      check("big_idle", 128'(bif.busy), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
